// File: rtl/slow_clk_tick_rx_if.sv
// Tick and status bundle between the divided-clock receiver and the game-step consumer.
// master = receiver side (drives tick/status), slave = consumer side (drives enable/ready/clear).
interface slow_clk_tick_rx_if #(
    parameter int PERIOD_W = 16,
    parameter int MISS_W   = 4
);
    logic                en;
    logic                tick_valid;
    logic                tick_ready;
    logic                clr_missed;
    logic [MISS_W-1:0]   missed;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;

    modport master (
        input  en, tick_ready, clr_missed,
        output tick_valid, missed, period, period_valid
    );

    modport slave (
        output en, tick_ready, clr_missed,
        input  tick_valid, missed, period, period_valid
    );
endinterface

// File: rtl/slow_clk_tick_rx.sv
// Synchronises the divided clock, turns each accepted rising edge into a ready/valid tick and measures its period.
// Latency: clk_d rise to tick_valid is SYNC_STAGES+1 clk edges; all outputs registered.
// Backpressure: a tick arriving while one is still pending is dropped and counted in missed (saturating).
module slow_clk_tick_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_W    = 16,
    parameter int MISS_W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_d,
    slow_clk_tick_rx_if.master  rx
);
    localparam logic [PERIOD_W-1:0] CNT_MAX  = {PERIOD_W{1'b1}};
    localparam logic [MISS_W-1:0]   MISS_MAX = {MISS_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   tick_q,    tick_d;
    logic [MISS_W-1:0]      miss_q,    miss_d;
    logic [PERIOD_W-1:0]    cnt_q,     cnt_d;
    logic [PERIOD_W-1:0]    per_q,     per_d;
    logic                   per_vld_q, per_vld_d;
    logic                   ref_q,     ref_d;

    logic last_stage, rise, acc, hs, miss;

    assign last_stage = sync_q[SYNC_STAGES-1];
    assign rise       = last_stage & ~prev_q;
    assign acc        = rx.en & rise;
    assign hs         = tick_q & rx.tick_ready;
    assign miss       = acc & tick_q & ~hs;

    always_comb begin
        tick_d = tick_q;
        if (acc)
            tick_d = 1'b1;
        else if (hs)
            tick_d = 1'b0;

        miss_d = miss_q;
        if (rx.clr_missed)
            miss_d = miss ? MISS_W'(1) : '0;
        else if (miss && miss_q != MISS_MAX)
            miss_d = miss_q + MISS_W'(1);

        cnt_d = cnt_q;
        if (acc)
            cnt_d = '0;
        else if (rx.en && cnt_q != CNT_MAX)
            cnt_d = cnt_q + PERIOD_W'(1);

        // Only a rise with a valid reference rise before it yields a period sample.
        per_d     = per_q;
        per_vld_d = 1'b0;
        if (acc && ref_q) begin
            per_vld_d = 1'b1;
            per_d     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + PERIOD_W'(1);
        end

        ref_d = ref_q;
        if (!rx.en)
            ref_d = 1'b0;
        else if (acc)
            ref_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            tick_q    <= 1'b0;
            miss_q    <= '0;
            cnt_q     <= '0;
            per_q     <= '0;
            per_vld_q <= 1'b0;
            ref_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], clk_d};
            prev_q    <= last_stage;
            tick_q    <= tick_d;
            miss_q    <= miss_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            per_vld_q <= per_vld_d;
            ref_q     <= ref_d;
        end
    end

    assign rx.tick_valid   = tick_q;
    assign rx.missed       = miss_q;
    assign rx.period       = per_q;
    assign rx.period_valid = per_vld_q;
endmodule

// File: tb/tb_slow_clk_tick_rx.sv
// Scoreboard bench: stimulus pushes expected handshake cycles and period samples, a negedge monitor pops and compares.
module tb_slow_clk_tick_rx;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clk_d = 1'b0;

    slow_clk_tick_rx_if #(.PERIOD_W(16), .MISS_W(4)) dif ();
    slow_clk_tick_rx_if #(.PERIOD_W(16), .MISS_W(2)) sif ();

    slow_clk_tick_rx #(.SYNC_STAGES(2), .PERIOD_W(16), .MISS_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .clk_d(clk_d), .rx(dif.master));
    slow_clk_tick_rx #(.SYNC_STAGES(2), .PERIOD_W(16), .MISS_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .clk_d(clk_d), .rx(sif.master));

    always #5 clk = ~clk;

    typedef struct { int cyc; int val; } per_t;
    int   tick_q[$];
    per_t per_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   ref_ok = 1'b0;
    int   last_rise = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every handshake and every period strobe must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dif.tick_valid && dif.tick_ready) begin
                if (tick_q.size() == 0) check("unexpected_tick", cyc, 0);
                else check("tick_cycle", cyc, tick_q.pop_front());
            end
            if (dif.period_valid) begin
                if (per_q.size() == 0) check("unexpected_period", cyc, 0);
                else begin
                    per_t e;
                    e = per_q.pop_front();
                    check("period_cycle", cyc, e.cyc);
                    check("period_value", 32'(dif.period), e.val);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_en(input bit v);
        dif.en = v;
        if (!v) ref_ok = 1'b0;
    endtask

    // Raise clk_d right after an edge and record what the receiver must produce for it.
    task automatic rise_now(input bit hs_exp);
        int b;
        per_t p;
        step(1);
        clk_d = 1'b1;
        b = cyc;
        if (hs_exp) tick_q.push_back(b + 3);
        if (ref_ok) begin
            p.cyc = b + 3;
            p.val = (b - last_rise > 65535) ? 65535 : b - last_rise;
            per_q.push_back(p);
        end
        ref_ok    = 1'b1;
        last_rise = b;
    endtask

    task automatic train(input int n, input int hi, input int lo, input bit hs_exp);
        for (int i = 0; i < n; i++) begin
            rise_now(hs_exp);
            step(hi);
            clk_d = 1'b0;
            step(lo - 1);
        end
    endtask

    initial begin
        int b1, b2;
        dif.en = 1'b1; dif.tick_ready = 1'b1; dif.clr_missed = 1'b0;
        sif.en = 1'b1; sif.tick_ready = 1'b0; sif.clr_missed = 1'b0;

        // Reset state
        step(3);
        check("rst_tick_valid", 32'(dif.tick_valid), 0);
        check("rst_missed", 32'(dif.missed), 0);
        check("rst_period", 32'(dif.period), 0);
        check("rst_period_valid", 32'(dif.period_valid), 0);
        rst_n = 1'b1;
        step(3);

        // 1: divide-by-4, always ready
        train(5, 2, 2, 1'b1);
        step(3);
        check("t1_missed", 32'(dif.missed), 0);
        check("t1_sat_missed", 32'(sif.missed), 3);

        // 2: consumer stalled, misses accumulate; clear alone and clear with a miss
        dif.tick_ready = 1'b0;
        set_en(1'b0); step(1); set_en(1'b1);
        train(5, 2, 2, 1'b0);
        step(2);
        check("t2_tick_held", 32'(dif.tick_valid), 1);
        check("t2_missed4", 32'(dif.missed), 4);
        rise_now(1'b0);
        step(2);
        dif.clr_missed = 1'b1;
        step(1);
        dif.clr_missed = 1'b0;
        check("t2_clr_with_miss", 32'(dif.missed), 1);
        step(1);
        clk_d = 1'b0;
        dif.clr_missed = 1'b1;
        step(1);
        dif.clr_missed = 1'b0;
        check("t2_clr", 32'(dif.missed), 0);
        tick_q.push_back(cyc);
        dif.tick_ready = 1'b1;
        step(1);
        check("t2_retired", 32'(dif.tick_valid), 0);
        check("t2_sat_missed", 32'(sif.missed), 3);
        step(3);

        // 3: handshake on the same edge a new rise is accepted
        dif.tick_ready = 1'b0;
        rise_now(1'b0);
        b1 = cyc;
        step(2);
        clk_d = 1'b0;
        step(1);
        check("t3_first_valid", 32'(dif.tick_valid), 1);
        rise_now(1'b0);
        b2 = cyc;
        check("t3_rise_spacing", b2 - b1, 4);
        step(2);
        dif.tick_ready = 1'b1;
        tick_q.push_back(b2 + 2);
        tick_q.push_back(b2 + 3);
        step(1);
        check("t3_valid_kept", 32'(dif.tick_valid), 1);
        check("t3_missed_kept", 32'(dif.missed), 0);
        step(1);
        check("t3_valid_dropped", 32'(dif.tick_valid), 0);
        clk_d = 1'b0;
        step(3);

        // 4: very long low phase saturates the period
        train(2, 2, 70000, 1'b1);
        step(4);

        // 5: disabled receiver ignores edges; re-enable while clk_d is high
        set_en(1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1); clk_d = 1'b1; step(2); clk_d = 1'b0; step(2);
        end
        check("t5_no_tick", 32'(dif.tick_valid), 0);
        step(1); clk_d = 1'b1; step(4);
        set_en(1'b1);
        step(4);
        check("t5_no_tick_reenable", 32'(dif.tick_valid), 0);
        clk_d = 1'b0;
        step(2);
        train(2, 2, 2, 1'b1);
        step(4);

        // 6: asynchronous reset mid-stream
        dif.tick_ready = 1'b0;
        train(3, 2, 2, 1'b0);
        step(3);
        check("t6_pre_valid", 32'(dif.tick_valid), 1);
        check("t6_pre_missed", 32'(dif.missed), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tick_valid", 32'(dif.tick_valid), 0);
        check("t6_rst_missed", 32'(dif.missed), 0);
        check("t6_rst_period", 32'(dif.period), 0);
        check("t6_rst_period_valid", 32'(dif.period_valid), 0);
        clk_d = 1'b0;
        ref_ok = 1'b0;
        step(2);
        rst_n = 1'b1;
        dif.tick_ready = 1'b1;
        train(2, 2, 2, 1'b1);
        step(10);

        check("tick_queue_drained", tick_q.size(), 0);
        check("period_queue_drained", per_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
